// File: rtl/pool_pkg.sv
// Shared definitions for the pooling reducer: mode codes, FSM encoding and
// accumulator sizing.
package pool_pkg;

   localparam logic POOL_MAX = 1'b0;
   localparam logic POOL_AVG = 1'b1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   // Wide enough to sum NIN*MAXB full-scale signed samples without overflow.
   function automatic int acc_width(input int bd, input int nin, input int maxb);
      return bd + $clog2(nin * maxb);
   endfunction

endpackage

// File: rtl/lane_reduce.sv
// Combinational reduction of one beat: signed max and sign-extended sum of
// NIN lanes, built as a balanced binary tree.
module lane_reduce #(
   parameter int BD  = 18,
   parameter int NIN = 2,
   parameter int AW  = 23
) (
   input  logic [NIN*BD-1:0] in_data,
   output logic [BD-1:0]     lane_max,
   output logic [AW-1:0]     lane_sum
);

   // Leaves are padded to a power of two; pads are the most negative value
   // for max and zero for sum so they never influence the result.
   localparam int P = 1 << $clog2(NIN);

   always_comb begin
      logic [BD-1:0] mx [2*P-1];
      logic [AW-1:0] sm [2*P-1];
      for (int n = 0; n < 2*P-1; n++) begin
         mx[n] = '0;
         sm[n] = '0;
      end
      for (int k = 0; k < NIN; k++) begin
         mx[P-1+k] = in_data[k*BD +: BD];
         sm[P-1+k] = {{(AW-BD){in_data[k*BD+BD-1]}}, in_data[k*BD +: BD]};
      end
      for (int k = NIN; k < P; k++) begin
         mx[P-1+k] = {1'b1, {(BD-1){1'b0}}};
         sm[P-1+k] = '0;
      end
      for (int n = P-2; n >= 0; n--) begin
         mx[n] = ($signed(mx[2*n+1]) >= $signed(mx[2*n+2])) ? mx[2*n+1] : mx[2*n+2];
         sm[n] = sm[2*n+1] + sm[2*n+2];
      end
      lane_max = mx[0];
      lane_sum = sm[0];
   end

endmodule

// File: rtl/pool_reduce_n.sv
// Pooling-window reducer: max or shifted-sum over a configurable number of
// NIN-lane beats, with valid/ready on both sides; state moves on the falling edge.
module pool_reduce_n
   import pool_pkg::*;
#(
   parameter int BD   = 18,
   parameter int NIN  = 2,
   parameter int MAXB = 16,
   parameter int BW   = 5,
   parameter int SW   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BW-1:0]     cfg_beats,
   input  logic              cfg_mode,
   input  logic [SW-1:0]     cfg_shift,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NIN*BD-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BD-1:0]     out_data,
   output logic [15:0]       out_cnt
);

   localparam int AW = acc_width(BD, NIN, MAXB);
   localparam logic [AW-1:0] SAT_HI = {{(AW-BD+1){1'b0}}, {(BD-1){1'b1}}};
   localparam logic [AW-1:0] SAT_LO = {{(AW-BD+1){1'b1}}, {(BD-1){1'b0}}};

   state_t        state;
   logic [AW-1:0] acc;
   logic [BW-1:0] cnt;
   logic [BW-1:0] sh_beats;
   logic          sh_mode;
   logic [SW-1:0] sh_shift;

   logic [BD-1:0] lane_max;
   logic [AW-1:0] lane_sum;

   lane_reduce #(.BD(BD), .NIN(NIN), .AW(AW)) u_lane_reduce (
      .in_data  (in_data),
      .lane_max (lane_max),
      .lane_sum (lane_sum)
   );

   // Handshake: a beat is taken when in_valid && in_ready; in_ready drops while
   // a result is held without being drained, during clr, and during reset.
   // The output register moves when out_valid && out_ready.
   assign in_ready = reset && !(out_valid && !out_ready) && !clr;

   logic                 accept;
   logic                 first;
   logic                 mode_eff;
   logic [BW-1:0]        beats_eff;
   logic [SW-1:0]        shift_eff;
   logic [BW-1:0]        cnt_nxt;
   logic                 last;
   logic [AW-1:0]        max_ext;
   logic [AW-1:0]        acc_nxt;
   logic signed [AW-1:0] shifted;
   logic [BD-1:0]        res;

   assign accept = in_valid && in_ready;
   assign first  = (state == S_IDLE);

   // The first beat of a window uses the live config; later beats use the shadow copy.
   always_comb begin
      mode_eff  = first ? cfg_mode : sh_mode;
      beats_eff = first ? ((cfg_beats == '0) ? BW'(1) : cfg_beats) : sh_beats;
      shift_eff = first ? cfg_shift : sh_shift;
      cnt_nxt   = first ? BW'(1) : cnt + BW'(1);
      last      = (cnt_nxt == beats_eff);
      max_ext   = {{(AW-BD){lane_max[BD-1]}}, lane_max};
      if (mode_eff == POOL_AVG)
         acc_nxt = first ? lane_sum : acc + lane_sum;
      else if (first || ($signed(max_ext) > $signed(acc)))
         acc_nxt = max_ext;
      else
         acc_nxt = acc;
      shifted = $signed(acc_nxt) >>> shift_eff;
      if (mode_eff == POOL_AVG) begin
         if (shifted > $signed(SAT_HI))
            res = SAT_HI[BD-1:0];
         else if (shifted < $signed(SAT_LO))
            res = SAT_LO[BD-1:0];
         else
            res = shifted[BD-1:0];
      end else begin
         res = acc_nxt[BD-1:0];
      end
   end

   always_ff @(negedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         sh_beats  <= '0;
         sh_mode   <= POOL_MAX;
         sh_shift  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (clr) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
         end else if (accept) begin
            if (first) begin
               sh_beats <= beats_eff;
               sh_mode  <= cfg_mode;
               sh_shift <= cfg_shift;
            end
            if (last) begin
               out_valid <= 1'b1;
               out_data  <= res;
               out_cnt   <= out_cnt + 16'd1;
               state     <= S_IDLE;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               state <= S_ACC;
               acc   <= acc_nxt;
               cnt   <= cnt_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_pool_reduce_n.sv
// Directed bench for pool_reduce_n: a table of whole windows plus hand-written
// sequences for config freeze, backpressure, clr and reset.
module tb_pool_reduce_n;

   localparam int BD   = 18;
   localparam int NIN  = 2;
   localparam int MAXB = 16;
   localparam int BW   = 5;
   localparam int SW   = 4;

   logic              clk = 1'b1;
   logic              reset = 1'b0;
   logic [BW-1:0]     cfg_beats = '0;
   logic              cfg_mode = 1'b0;
   logic [SW-1:0]     cfg_shift = '0;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NIN*BD-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [BD-1:0]     out_data;
   logic [15:0]       out_cnt;

   pool_reduce_n #(.BD(BD), .NIN(NIN), .MAXB(MAXB), .BW(BW), .SW(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_beats (cfg_beats),
      .cfg_mode  (cfg_mode),
      .cfg_shift (cfg_shift),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [BD-1:0] exp_q[$];
   logic [15:0]   exp_cnt = '0;

   typedef struct {
      logic [BW-1:0]     beats;
      logic              mode;
      logic [SW-1:0]     shift;
      int                nb;
      bit                bubble;
      logic [NIN*BD-1:0] d0;
      logic [NIN*BD-1:0] d1;
      logic [NIN*BD-1:0] d2;
      logic [BD-1:0]     exp;
   } vec_t;

   vec_t vt[10];

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the falling edge; outputs are sampled there too.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [NIN*BD-1:0] lanes(input logic [BD-1:0] l0, input logic [BD-1:0] l1);
      return {l1, l0};
   endfunction

   task automatic beat(input logic [BD-1:0] l0, input logic [BD-1:0] l1);
      in_valid = 1'b1;
      in_data  = lanes(l0, l1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [BW-1:0] b, input logic m, input logic [SW-1:0] s);
      cfg_beats = b;
      cfg_mode  = m;
      cfg_shift = s;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_result(input logic [BD-1:0] d);
      exp_q.push_back(d);
      exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic check_result(input string name);
      logic [BD-1:0] e;
      e = exp_q.pop_front();
      check({name, ".valid"}, 32'(out_valid), 32'd1);
      check({name, ".data"}, 32'(out_data), 32'(e));
      check({name, ".cnt"}, 32'(out_cnt), 32'(exp_cnt));
   endtask

   function automatic vec_t mk(input logic [BW-1:0] b, input logic m, input logic [SW-1:0] s,
                               input int nb, input bit bub,
                               input logic [NIN*BD-1:0] d0, input logic [NIN*BD-1:0] d1,
                               input logic [NIN*BD-1:0] d2, input logic [BD-1:0] e);
      vec_t v;
      v.beats = b; v.mode = m; v.shift = s; v.nb = nb; v.bubble = bub;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.exp = e;
      return v;
   endfunction

   // ---------------- test ----------------
   initial begin
      vt[0] = mk(5'd2, 1'b0, 4'd0, 2, 1'b0, lanes(18'h3FFFE, 18'h3FFFF), lanes(18'h3FFFD, 18'h20000), '0, 18'h3FFFF);
      vt[1] = mk(5'd1, 1'b0, 4'd0, 1, 1'b0, lanes(18'h1FFFF, 18'h20000), '0, '0, 18'h1FFFF);
      vt[2] = mk(5'd1, 1'b0, 4'd0, 1, 1'b0, lanes(18'h00000, 18'h3FFFF), '0, '0, 18'h00000);
      vt[3] = mk(5'd2, 1'b1, 4'd2, 2, 1'b0, lanes(18'd4, 18'd8), lanes(18'h3FFFC, 18'd12), '0, 18'd5);
      vt[4] = mk(5'd2, 1'b1, 4'd0, 2, 1'b0, lanes(18'h1FFFF, 18'h1FFFF), lanes(18'h1FFFF, 18'h1FFFF), '0, 18'h1FFFF);
      vt[5] = mk(5'd2, 1'b1, 4'd0, 2, 1'b0, lanes(18'h20000, 18'h20000), lanes(18'h20000, 18'h20000), '0, 18'h20000);
      vt[6] = mk(5'd1, 1'b1, 4'd1, 1, 1'b0, lanes(18'h3FFFD, 18'd0), '0, '0, 18'h3FFFE);
      vt[7] = mk(5'd0, 1'b0, 4'd0, 1, 1'b0, lanes(18'd5, 18'd7), '0, '0, 18'd7);
      vt[8] = mk(5'd3, 1'b0, 4'd0, 3, 1'b1, lanes(18'h3FFF9, 18'd3), lanes(18'd10, 18'h3FFFF), lanes(18'd2, 18'd4), 18'd10);
      vt[9] = mk(5'd3, 1'b1, 4'd1, 3, 1'b1, lanes(18'd1, 18'd2), lanes(18'd3, 18'h3FFF6), lanes(18'd5, 18'd6), 18'd3);

      // Reset state
      reset = 1'b0;
      in_valid = 1'b1;
      step();
      step();
      check("reset.in_ready", 32'(in_ready), 32'd0);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.out_data", 32'(out_data), 32'd0);
      check("reset.out_cnt", 32'(out_cnt), 32'd0);
      in_valid = 1'b0;
      reset = 1'b1;
      step();

      // Table of whole windows with the output always drained
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_cfg(vt[i].beats, vt[i].mode, vt[i].shift);
         expect_result(vt[i].exp);
         for (int j = 0; j < vt[i].nb; j++) begin
            if (vt[i].bubble && j == 1) begin
               in_valid = 1'b0;
               step();
            end
            in_valid = 1'b1;
            in_data  = (j == 0) ? vt[i].d0 : (j == 1) ? vt[i].d1 : vt[i].d2;
            step();
            if (j == 0 && vt[i].nb > 1)
               check($sformatf("vec%0d.mid_valid", i), 32'(out_valid), 32'd0);
         end
         in_valid = 1'b0;
         check_result($sformatf("vec%0d", i));
      end

      // Longest window: 16 beats of full-scale positive lanes, sum >>> 5 fits exactly
      set_cfg(5'd16, 1'b1, 4'd5);
      expect_result(18'h1FFFF);
      for (int j = 0; j < 16; j++) begin
         beat(18'h1FFFF, 18'h1FFFF);
         if (j == 14)
            check("maxb.mid_valid", 32'(out_valid), 32'd0);
      end
      check_result("maxb");

      // Config changed mid-window is ignored until the next window
      set_cfg(5'd2, 1'b1, 4'd0);
      beat(18'd1, 18'd2);
      set_cfg(5'd1, 1'b0, 4'd3);
      expect_result(18'd10);
      beat(18'd3, 18'd4);
      check_result("cfg_freeze");

      // Backpressure: held result stalls input, then drain and reload in one edge
      step();
      check("bp.drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      set_cfg(5'd1, 1'b0, 4'd0);
      expect_result(18'd9);
      beat(18'd9, 18'd0);
      check_result("bp.first");
      in_valid = 1'b1;
      in_data  = lanes(18'd11, 18'd0);
      #1;
      check("bp.in_ready_low", 32'(in_ready), 32'd0);
      step();
      check("bp.held_data", 32'(out_data), 32'd9);
      check("bp.held_cnt", 32'(out_cnt), 32'(exp_cnt));
      out_ready = 1'b1;
      #1;
      check("bp.in_ready_high", 32'(in_ready), 32'd1);
      expect_result(18'd11);
      step();
      in_valid = 1'b0;
      check_result("bp.replace");
      step();
      check("bp.final_drain", 32'(out_valid), 32'd0);

      // clr keeps a held result
      out_ready = 1'b0;
      expect_result(18'h55);
      beat(18'h55, 18'd0);
      check_result("clr.hold_setup");
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr.hold_valid", 32'(out_valid), 32'd1);
      check("clr.hold_data", 32'(out_data), 32'h55);

      // Reset with a held result
      reset = 1'b0;
      in_valid = 1'b1;
      #1;
      check("rst.in_ready", 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0;
      reset = 1'b1;
      exp_cnt = '0;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.out_data", 32'(out_data), 32'd0);
      check("rst.out_cnt", 32'(out_cnt), 32'd0);

      // Reset mid-window drops the partial window
      out_ready = 1'b1;
      set_cfg(5'd2, 1'b0, 4'd0);
      beat(18'd50, 18'd0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rst_mid.out_cnt", 32'(out_cnt), 32'd0);
      beat(18'd1, 18'd0);
      expect_result(18'd2);
      beat(18'd2, 18'd0);
      check_result("rst_mid.fresh");

      // clr after 1 of 3 beats discards the in-flight beat and the partial window
      set_cfg(5'd3, 1'b0, 4'd0);
      beat(18'd100, 18'd0);
      clr = 1'b1;
      in_valid = 1'b1;
      in_data  = lanes(18'd200, 18'd0);
      #1;
      check("clr.in_ready", 32'(in_ready), 32'd0);
      step();
      clr = 1'b0;
      in_valid = 1'b0;
      check("clr.no_result", 32'(out_valid), 32'd0);
      check("clr.cnt", 32'(out_cnt), 32'(exp_cnt));
      beat(18'd1, 18'd2);
      beat(18'd3, 18'd4);
      expect_result(18'd6);
      beat(18'd5, 18'd6);
      check_result("clr.fresh");

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
